// File: rtl/dm_split_sequencer_if.sv
// Pipeline request/response and data-memory beat signals of the split sequencer.
// Handshakes: a beat transfers on a cycle with mem_req && mem_gnt; req_valid is held until rsp_valid.
interface dm_split_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              stall;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_be;
    logic [63:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall, rsp_valid, rsp_rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall, rsp_valid, rsp_rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/dm_split_sequencer.sv
// Splits MEM-stage loads/stores onto a 64-bit doubleword memory port, merging and
// extending load beats. rst_n is an asynchronous, active-high reset.
module dm_split_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dm_split_sequencer_if.slave  bus,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state, state_d;
    logic              wr_q, uns_q, two_q;
    logic [1:0]        size_q, rc_q;
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       mask_q;
    logic [127:0]      wide_q;
    logic [63:0]       buf0_q, rdata_q;
    // The top byte of beat 1 can never land inside the result, so it is not kept.
    logic [55:0]       buf1_q;

    logic [3:0]        n_bytes;
    logic [15:0]       mask_d;
    logic              two_d;
    logic [127:0]      wide_d;

    always_comb begin
        n_bytes = 4'd1 << bus.req_size;
        mask_d  = ((16'd1 << n_bytes) - 16'd1) << bus.req_addr[2:0];
        two_d   = ({1'b0, bus.req_addr[2:0]} + n_bytes) > 4'd8;
        wide_d  = {64'd0, bus.req_wdata} << {bus.req_addr[2:0], 3'b000};
    end

    logic              capture, load_done;
    logic [1:0]        rc_inc;
    logic [63:0]       b0, raw, ext;
    logic [55:0]       b1;
    logic [119:0]      pair;

    // Merge includes the beat arriving this cycle so DONE is entered with the final rvalid.
    always_comb begin
        capture   = bus.mem_rvalid && (state == ISSUE1 || state == WAIT);
        rc_inc    = rc_q + 2'd1;
        load_done = (state == WAIT) && bus.mem_rvalid && (rc_inc == (two_q ? 2'd2 : 2'd1));
        b0        = (capture && rc_q == 2'd0) ? bus.mem_rdata : buf0_q;
        b1        = (capture && rc_q == 2'd1) ? bus.mem_rdata[55:0] : buf1_q;
        pair      = {b1, b0};
        raw       = pair[{off_q, 3'b000} +: 64];
        case (size_q)
            2'd0:    ext = {{56{~uns_q & raw[7]}},  raw[7:0]};
            2'd1:    ext = {{48{~uns_q & raw[15]}}, raw[15:0]};
            2'd2:    ext = {{32{~uns_q & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            two_q   <= 1'b0;
            size_q  <= 2'd0;
            rc_q    <= 2'd0;
            off_q   <= 3'd0;
            base_q  <= '0;
            mask_q  <= 16'd0;
            wide_q  <= 128'd0;
            buf0_q  <= 64'd0;
            buf1_q  <= 56'd0;
            rdata_q <= 64'd0;
        end else begin
            state <= state_d;
            if (state == IDLE && bus.req_valid) begin
                wr_q   <= bus.req_wr;
                uns_q  <= bus.req_unsigned;
                two_q  <= two_d;
                size_q <= bus.req_size;
                rc_q   <= 2'd0;
                off_q  <= bus.req_addr[2:0];
                base_q <= {bus.req_addr[ADDR_W-1:3], 3'b000};
                mask_q <= mask_d;
                wide_q <= wide_d;
            end
            if (capture) begin
                rc_q <= rc_inc;
                if (rc_q == 2'd0) buf0_q <= bus.mem_rdata;
                if (rc_q == 2'd1) buf1_q <= bus.mem_rdata[55:0];
            end
            if (load_done) rdata_q <= ext;
        end
    end

    always_comb begin
        state_d       = state;
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 8'd0;
        bus.mem_wdata = 64'd0;
        case (state)
            IDLE: begin
                // Keep every output low while reset is held, even with a request pending.
                bus.stall = bus.req_valid && !rst_n;
                if (bus.req_valid) state_d = ISSUE0;
            end
            ISSUE0: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = wr_q;
                bus.mem_addr  = base_q;
                bus.mem_be    = mask_q[7:0];
                bus.mem_wdata = wide_q[63:0];
                if (bus.mem_gnt) state_d = two_q ? ISSUE1 : (wr_q ? DONE : WAIT);
            end
            ISSUE1: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = wr_q;
                bus.mem_addr  = base_q + ADDR_W'(8);
                bus.mem_be    = mask_q[15:8];
                bus.mem_wdata = wide_q[127:64];
                if (bus.mem_gnt) state_d = wr_q ? DONE : WAIT;
            end
            WAIT: begin
                bus.stall = 1'b1;
                if (load_done) state_d = DONE;
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign dbg_state     = state;
endmodule

// File: doc/dm_split_sequencer.md
Name: dm_split_sequencer

Overview:
- Sequences every data-memory load and store from the MEM stage onto a 64-bit, doubleword-addressed data memory port.
- Any access that crosses a doubleword boundary is split into two memory beats (a misaligned half-word, word or double-word). The block computes per-beat byte enables and lane-shifted store data.
- For loads it merges the returned beats, then sign- or zero-extends the result.
- It stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-high.
- req_valid  in  1  MEM stage presents a memory op; held stable while stall=1.
- req_wr  in  1  1=store, 0=load.
- req_size  in  2  00=B, 01=HW, 10=W, 11=DW.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, right-aligned.
- stall  out  1  freeze pipeline.
- rsp_valid  out  1  one-cycle pulse: op complete; load data is valid.
- rsp_rdata  out  64  extended load result.
- mem_req  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  doubleword-aligned beat address; bits [2:0] always 0.
- mem_be  out  8  byte enables.
- mem_wdata  out  64  lane-aligned write data.
- mem_gnt  in  1  memory accepts the presented beat this cycle.
- mem_rvalid  in  1  read data return; one per accepted read beat, in order, at least 1 cycle after its gnt.
- mem_rdata  in  64  read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, all internal buffers and counters 0.
- Reset asserted mid-operation aborts the op. Any mem_rvalid arriving after reset is ignored.
- Decode, done at acceptance and latched:
  - off = addr[2:0]; n = 1<<size; mask = (2^n − 1) << off, 16 bits wide.
  - beats = 2 if off+n > 8, else 1.
  - base = {addr[ADDR_W-1:3], 3'b0}.
  - Beat0: addr = base, be = mask[7:0].
  - Beat1: addr = base+8 modulo 2^ADDR_W (wraps to 0), be = mask[15:8].
  - Store data: wide = {64'b0, req_wdata} << 8*off, 128 bits. Beat0 drives wide[63:0]; beat1 drives wide[127:64].
- States: IDLE, ISSUE0, ISSUE1, WAIT, DONE.
- IDLE:
  - mem_req=0; stall = req_valid.
  - On req_valid: latch the decode; go to ISSUE0.
- ISSUE0:
  - mem_req=1; mem_we = latched wr; beat0 fields driven; stall=1.
  - Fields stay stable until mem_gnt.
  - On gnt: if beats=2 go to ISSUE1; else a store goes to DONE and a load goes to WAIT.
- ISSUE1:
  - Beat1 fields driven; stall=1.
  - On gnt: a store goes to DONE; a load goes to WAIT.
- WAIT: mem_req=0; stall=1.
- Read capture, in ISSUE1 and WAIT:
  - A 2-bit return counter rc counts mem_rvalid pulses.
  - rc=0 captures into buf0; rc=1 captures into buf1.
  - When rc reaches beats (including the cycle of the final rvalid), compute the result and go to DONE.
  - A beat0 rvalid in the same cycle as the beat1 gnt is legal and is captured.
  - mem_rvalid in IDLE or DONE is ignored.
- Load merge:
  - raw = ({buf1, buf0} >> 8*off)[63:0], truncated to n bytes.
  - Extend to 64 bits: sign bit = bit 8n−1 unless req_unsigned.
  - rsp_rdata is registered on entry to DONE. It holds its value until the next load's DONE and is unchanged by stores.
- DONE:
  - rsp_valid=1, stall=0, mem_req=0.
  - Request inputs are ignored this cycle (same op still presented).
  - Go to IDLE unconditionally.
- mem_gnt while mem_req=0 is ignored.
- Minimum latency with gnt on first cycle and rvalid 1 cycle after gnt:
  - 1-beat store: 2 stall cycles, rsp_valid in cycle 2.
  - 1-beat load: rsp_valid in cycle 3.
  - 2-beat store: rsp_valid in cycle 3.
- Byte/HW/W/DW aligned accesses always take 1 beat. DW with off≠0 always takes 2 beats.

Test Plan:
- SW: addr 0x100, wdata 0x11223344, immediate gnt → one beat: mem_addr 0x100, be 0x0F, wdata[31:0]=0x11223344. rsp_valid in cycle 2; stall high in cycles 0–1.
- SH: addr 0x107, wdata 0xBEEF → beat0: addr 0x100, be 0x80, wdata[63:56]=0xEF. Beat1: addr 0x108, be 0x01, wdata[7:0]=0xBE. Exactly one rsp_valid.
- LW signed: addr 0x20E; beat0 rdata 0xAABB_0000_0000_0000, beat1 rdata 0x0000_0000_0000_CCDD → rsp_rdata 0xFFFF_FFFF_CCDD_AABB. Repeat with req_unsigned=1 → 0x0000_0000_CCDD_AABB.
- LB at addr 0x3, rdata 0x0000_0000_8000_0000 → rsp_rdata 0xFFFF_FFFF_FFFF_FF80. LBU → 0x0000_0000_0000_0080.
- Backpressure: SD at addr 0x1004 with gnt held low 3 cycles per beat → mem_req/addr/be/wdata stable while waiting. be0=0xF0, be1=0x0F; stall continuous; rsp_valid once.
- Wrap and reset, with ADDR_W=32:
  - LD at 0xFFFF_FFFC → beat1 mem_addr 0x0000_0000.
  - Assert rst_n while in WAIT → all outputs 0 within the same cycle; subsequent mem_rvalid produces no rsp_valid; next request proceeds normally.
